// File: rtl/demux4_dispatch.sv
// 1-to-4 valid/ready dispatcher: one input stream is routed to one of four
// single-word holding slots, chosen by an explicit select or a round-robin pointer.
module demux4_dispatch #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               auto_rr,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [1:0]         rr_ptr,
    output logic [7:0]         xfer_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t      state_q [4];
    slot_state_t      state_d [4];
    logic [WIDTH-1:0] data_q  [4];
    logic [WIDTH-1:0] data_d  [4];
    logic [1:0]       rr_ptr_q;
    logic [1:0]       rr_ptr_d;
    logic [7:0]       xfer_cnt_q;
    logic [7:0]       xfer_cnt_d;

    logic [1:0] tgt;
    logic       acc;

    assign tgt = auto_rr ? rr_ptr_q : in_sel;

    // A full slot can still take a word in the same cycle its consumer drains it.
    assign in_ready = (state_q[tgt] == EMPTY) | out_ready[tgt];
    assign acc      = in_valid & in_ready;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        xfer_cnt_d = xfer_cnt_q;
        for (int k = 0; k < 4; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            if (acc && (tgt == 2'(k))) begin
                state_d[k] = FULL;
                data_d[k]  = in_data;
            end else if ((state_q[k] == FULL) && out_ready[k]) begin
                state_d[k] = EMPTY;
            end
        end
        if (acc) begin
            xfer_cnt_d = xfer_cnt_q + 8'd1;
            if (auto_rr) begin
                rr_ptr_d = rr_ptr_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
            end
            rr_ptr_q   <= 2'd0;
            xfer_cnt_q <= 8'd0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
            rr_ptr_q   <= rr_ptr_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            out_valid[k]                = (state_q[k] == FULL);
            out_data[k*WIDTH +: WIDTH] = data_q[k];
        end
    end

    assign rr_ptr   = rr_ptr_q;
    assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_demux4_dispatch.sv
// Directed and randomized bench for demux4_dispatch, checked every cycle
// against a slot-level reference model.
module tb_demux4_dispatch;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic        auto_rr;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [1:0]  rr_ptr;
    logic [7:0]  xfer_cnt;

    int total;
    int bad;

    // Reference model: which slots hold a word, what word, pointer and count.
    bit       m_valid [4];
    bit [7:0] m_data  [4];
    int       m_ptr;
    int       m_cnt;

    demux4_dispatch #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .auto_rr   (auto_rr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rr_ptr    (rr_ptr),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic int model_target();
        return auto_rr ? m_ptr : int'(in_sel);
    endfunction

    function automatic bit model_ready();
        int t;
        t = model_target();
        return !m_valid[t] || out_ready[t];
    endfunction

    function automatic logic [3:0] model_valid_vec();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = m_valid[k];
        return v;
    endfunction

    function automatic logic [31:0] model_data_vec();
        return {m_data[3], m_data[2], m_data[1], m_data[0]};
    endfunction

    task automatic set_inputs(input logic v, input logic [1:0] s, input logic [7:0] d,
                              input logic a, input logic [3:0] r, input logic rs);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        auto_rr   = a;
        out_ready = r;
        rst       = rs;
    endtask

    // One clock: check in_ready, advance the model at the edge, check outputs.
    task automatic apply_stimulus();
        int  t;
        bit  accept;
        #1;
        check_output("in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
        t      = model_target();
        accept = in_valid && model_ready();
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                m_valid[k] = 0;
                m_data[k]  = 8'h00;
            end
            m_ptr = 0;
            m_cnt = 0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (accept && k == t) begin
                    m_valid[k] = 1;
                    m_data[k]  = in_data;
                end else if (m_valid[k] && out_ready[k]) begin
                    m_valid[k] = 0;
                end
            end
            if (accept) begin
                m_cnt = (m_cnt + 1) % 256;
                if (auto_rr) m_ptr = (m_ptr + 1) % 4;
            end
        end
        #1;
        check_output("out_valid", {28'd0, out_valid}, {28'd0, model_valid_vec()});
        check_output("out_data", out_data, model_data_vec());
        check_output("rr_ptr", {30'd0, rr_ptr}, 32'(m_ptr));
        check_output("xfer_cnt", {24'd0, xfer_cnt}, 32'(m_cnt));
        @(negedge clk);
    endtask

    initial begin
        logic       hold_v;
        logic [1:0] hold_s;
        logic [7:0] hold_d;
        logic       stalled;

        total = 0;
        bad   = 0;
        for (int k = 0; k < 4; k++) begin
            m_valid[k] = 0;
            m_data[k]  = 8'h00;
        end
        m_ptr = 0;
        m_cnt = 0;
        set_inputs(0, 2'd0, 8'h00, 0, 4'b0000, 1);
        @(negedge clk);

        // Reset and idle
        apply_stimulus();
        apply_stimulus();
        check_output("rst_out_valid", {28'd0, out_valid}, 32'h0);
        check_output("rst_rr_ptr", {30'd0, rr_ptr}, 32'h0);
        check_output("rst_xfer_cnt", {24'd0, xfer_cnt}, 32'h0);
        set_inputs(0, 2'd0, 8'h00, 0, 4'b0000, 0);
        #1;
        check_output("idle_in_ready", {31'd0, in_ready}, 32'h1);

        // Explicit routing to channel 2, then drain it
        set_inputs(1, 2'd2, 8'hA5, 0, 4'b0000, 0);
        apply_stimulus();
        check_output("route_valid", {28'd0, out_valid}, 32'b0100);
        check_output("route_data", {24'd0, out_data[23:16]}, 32'hA5);
        check_output("route_cnt", {24'd0, xfer_cnt}, 32'd1);
        set_inputs(0, 2'd2, 8'h00, 0, 4'b0100, 0);
        apply_stimulus();
        check_output("drain_valid", {28'd0, out_valid}, 32'h0);
        check_output("drain_keeps_data", {24'd0, out_data[23:16]}, 32'hA5);

        // Backpressure on channel 1, channel 0 unaffected
        set_inputs(1, 2'd1, 8'h77, 0, 4'b0000, 0);
        apply_stimulus();
        set_inputs(1, 2'd1, 8'h3C, 0, 4'b0000, 0);
        #1;
        check_output("bp_in_ready", {31'd0, in_ready}, 32'h0);
        apply_stimulus();
        check_output("bp_cnt", {24'd0, xfer_cnt}, 32'd2);
        check_output("bp_old_word", {24'd0, out_data[15:8]}, 32'h77);
        set_inputs(1, 2'd0, 8'h3C, 0, 4'b0000, 0);
        apply_stimulus();
        check_output("indep_valid", {28'd0, out_valid}, 32'b0011);
        check_output("indep_data", {24'd0, out_data[7:0]}, 32'h3C);
        set_inputs(0, 2'd0, 8'h00, 0, 4'b0011, 0);
        apply_stimulus();

        // Simultaneous drain and load on channel 3
        set_inputs(1, 2'd3, 8'h11, 0, 4'b0000, 0);
        apply_stimulus();
        set_inputs(1, 2'd3, 8'h22, 0, 4'b1000, 0);
        #1;
        check_output("dl_in_ready", {31'd0, in_ready}, 32'h1);
        apply_stimulus();
        check_output("dl_valid", {31'd0, out_valid[3]}, 32'h1);
        check_output("dl_data", {24'd0, out_data[31:24]}, 32'h22);
        set_inputs(0, 2'd0, 8'h00, 0, 4'b1111, 0);
        apply_stimulus();

        // Round-robin wrap: words 0x10..0x14 land on channels 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            check_output("rr_seq", {30'd0, rr_ptr}, 32'(i % 4));
            set_inputs(1, 2'd0, 8'(8'h10 + i), 1, 4'b1111, 0);
            apply_stimulus();
            check_output("rr_channel", {28'd0, out_valid}, 32'(1 << (i % 4)));
            check_output("rr_word", {24'd0, out_data[(i % 4) * 8 +: 8]}, 32'(8'h10 + i));
        end
        check_output("rr_final", {30'd0, rr_ptr}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            set_inputs(1, 2'd0, 8'(8'h60 + i), 1, 4'b1111, 0);
            apply_stimulus();
        end
        check_output("rr_back_to_0", {30'd0, rr_ptr}, 32'd0);

        // Channel 0 held full at pointer 0 stalls the round-robin
        set_inputs(1, 2'd0, 8'h99, 0, 4'b1110, 0);
        apply_stimulus();
        check_output("rr_hold_manual", {30'd0, rr_ptr}, 32'd0);
        set_inputs(1, 2'd2, 8'h5A, 1, 4'b1110, 0);
        #1;
        check_output("rr_stall_ready", {31'd0, in_ready}, 32'h0);
        apply_stimulus();
        check_output("rr_stall_ptr", {30'd0, rr_ptr}, 32'd0);
        set_inputs(0, 2'd0, 8'h00, 0, 4'b1111, 0);
        apply_stimulus();

        // Counter wrap after 256 accepted words
        set_inputs(0, 2'd0, 8'h00, 0, 4'b1111, 1);
        apply_stimulus();
        for (int i = 0; i < 255; i++) begin
            set_inputs(1, 2'd0, 8'(i), 1, 4'b1111, 0);
            apply_stimulus();
        end
        check_output("cnt_255", {24'd0, xfer_cnt}, 32'd255);
        set_inputs(1, 2'd0, 8'hFF, 1, 4'b1111, 0);
        apply_stimulus();
        check_output("cnt_wrap", {24'd0, xfer_cnt}, 32'd0);

        // Reset wins over an accept in the same cycle
        set_inputs(1, 2'd2, 8'hEE, 0, 4'b0000, 1);
        apply_stimulus();
        check_output("rst_acc_valid", {28'd0, out_valid}, 32'h0);
        check_output("rst_acc_data", out_data, 32'h0);
        check_output("rst_acc_ptr", {30'd0, rr_ptr}, 32'h0);
        check_output("rst_acc_cnt", {24'd0, xfer_cnt}, 32'h0);

        // Randomized traffic obeying the producer hold rule
        hold_v  = 0;
        hold_s  = 2'd0;
        hold_d  = 8'h00;
        stalled = 0;
        for (int i = 0; i < 600; i++) begin
            logic a;
            logic [3:0] r;
            logic rs;
            a  = (($urandom % 4) == 0) ? ~auto_rr : auto_rr;
            r  = 4'($urandom);
            rs = (($urandom % 60) == 0);
            if (!stalled) begin
                hold_v = ($urandom % 4) != 0;
                hold_s = 2'($urandom);
                hold_d = 8'($urandom);
            end else begin
                a = auto_rr;
            end
            set_inputs(hold_v, hold_s, hold_d, a, r, rs);
            if (stalled) begin
                check_output("producer_hold", {23'd0, in_valid, in_sel, in_data},
                             {23'd0, hold_v, hold_s, hold_d});
            end
            stalled = in_valid && !model_ready() && !rs;
            apply_stimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux4_dispatch.md
Name: demux4_dispatch

Overview:
1-to-4 demultiplexer and dispatcher. It routes a single valid/ready input stream to one of four output channels, and is the counterpart of the 4:1 selection path. Each channel has a one-word holding register with its own valid/ready handshake. The target channel comes either from an explicit select or from an internal round-robin pointer.

Parameters:
WIDTH, 8, data word width in bits

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_data  input  WIDTH  input word
in_sel  input  2  explicit target channel (used when auto_rr=0)
in_valid  input  1  producer has a word
in_ready  output  1  block accepts word this cycle
auto_rr  input  1  1: target = round-robin pointer, in_sel ignored
out_data  output  4*WIDTH  channel k word at bits [k*WIDTH +: WIDTH]
out_valid  output  4  channel k holds a word
out_ready  input  4  consumer k takes word
rr_ptr  output  2  current round-robin pointer
xfer_cnt  output  8  count of accepted input words

Behaviour:
- Interface: one clock (clk); rst synchronous, active-high, sampled on rising edge of clk.
- Reset values: out_valid=0000, out_data=0, rr_ptr=0, xfer_cnt=0. rst has priority over every event in the same cycle. A word in flight at reset is dropped.
- Target channel: tgt = auto_rr ? rr_ptr : in_sel (combinational).
- Per-channel FSM, 2 states, EMPTY and FULL; out_valid[k] = (state_k==FULL).
  - EMPTY -> FULL on load(k).
  - FULL -> EMPTY on out_valid[k]&out_ready[k] with no load(k).
  - FULL -> FULL on simultaneous drain and load; new word replaces old, out_valid[k] stays 1.
- in_ready = (state_tgt==EMPTY) | out_ready[tgt]. It is combinational from tgt, FSM state and out_ready. It has no path from in_valid.
- Accept: acc = in_valid & in_ready.
  - load(tgt) = acc; slot tgt captures in_data.
  - out_valid[tgt]=1 and data visible on the cycle after acc (latency 1).
- Non-target channels are unaffected by acc. Each drains independently, so up to 4 drains per cycle are legal.
- out_data[k] holds its value until the next load(k). It is not cleared on drain.
- rr_ptr advances (+1 mod 4, 3 -> 0) only on acc with auto_rr=1. It holds otherwise, including while auto_rr=0. Toggling auto_rr does not reset it.
- xfer_cnt increments on every acc, 8-bit wrap 255 -> 0.
- Producer rule: in_data, in_sel and in_valid stay stable while in_valid & !in_ready. This is not checked in RTL; the bench asserts it.
- Round-robin stall: if the pointed-to channel is FULL and not draining, in_ready=0. The pointer does not skip ahead, so ordering is strict.

Test Plan:
- Reset and idle: assert rst for 2 cycles -> out_valid=0000, rr_ptr=0, xfer_cnt=0, in_ready=1.
- Explicit routing: auto_rr=0, in_sel=2, in_data=0xA5, in_valid for 1 cycle, out_ready=0000 -> next cycle out_valid=0100, out_data[23:16]=0xA5, xfer_cnt=1. Then out_ready[2]=1 for 1 cycle -> out_valid=0000, out_data[23:16] still 0xA5.
- Backpressure and independence: ch1 FULL with out_ready[1]=0, in_sel=1, in_data=0x3C -> in_ready=0, xfer_cnt unchanged, ch1 keeps old word. Switch in_sel=0 -> accepted, out_valid=0011.
- Simultaneous drain and load: ch3 FULL with 0x11, out_ready[3]=1, in_sel=3, in_data=0x22 in the same cycle -> in_ready=1, next cycle out_valid[3]=1, out_data[31:24]=0x22.
- Round-robin wrap: auto_rr=1, out_ready=1111, words 0x10..0x14 -> channels 0,1,2,3,0 in order, rr_ptr sequence 0,1,2,3,0,1. With ch0 held FULL (out_ready[0]=0) at rr_ptr=0 -> in_ready=0, rr_ptr stays 0.
- Reset mid-operation and counter wrap: 256 accepted words -> xfer_cnt=0. rst asserted in the same cycle as acc -> all outputs at reset values next cycle, word dropped.
